// File: rtl/vtg_pkg.sv
// Shared geometry defaults, NTSC/PAL raster start values and mode enum for video_timing_gen.
package vtg_pkg;

    localparam int unsigned VTG_CLK_DIV           = 4;
    localparam int unsigned VTG_H_TOTAL           = 384;
    localparam int unsigned VTG_H_ACTIVE          = 320;
    localparam int unsigned VTG_H_SYNC_START      = 336;
    localparam int unsigned VTG_H_SYNC_LEN        = 28;
    localparam int unsigned VTG_RW                = 9;
    localparam int unsigned VTG_RASTER_START_NTSC = 'h0F8;
    localparam int unsigned VTG_RASTER_START_PAL  = 'h0C8;
    localparam int unsigned VTG_V_ACT_START       = 'h110;
    localparam int unsigned VTG_V_ACT_END         = 'h1F0;
    localparam int unsigned VTG_V_SYNC_LEN        = 8;

    typedef enum logic {
        VTG_NTSC = 1'b0,
        VTG_PAL  = 1'b1
    } vtg_mode_e;

    // Half-open window test [lo, hi) on counter values widened to 32 bits
    function automatic logic in_window(input int unsigned v, input int unsigned lo,
                                       input int unsigned hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vtg_counter.sv
// Enable/wrap/load counter with terminal-count flag and exposed next value for registered decodes.
module vtg_counter #(
    parameter int unsigned W   = 9,
    parameter int unsigned MAX = 511
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] rst_val,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         tc_c,
    output logic [W-1:0] next_c
);

    assign tc_c = (count == W'(MAX));

    always_comb begin
        next_c = count;
        if (load) begin
            next_c = load_val;
        end else if (en) begin
            next_c = tc_c ? '0 : count + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= rst_val;
        end else begin
            count <= next_c;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Pixel/raster timing generator with registered sync and blank decodes.
// Optional raster-compare interrupt built when VIDEO_TIMING_GEN_RASTER_IRQ_EN is defined.
module video_timing_gen
    import vtg_pkg::*;
#(
    parameter int unsigned CLK_DIV           = VTG_CLK_DIV,
    parameter int unsigned H_TOTAL           = VTG_H_TOTAL,
    parameter int unsigned H_ACTIVE          = VTG_H_ACTIVE,
    parameter int unsigned H_SYNC_START      = VTG_H_SYNC_START,
    parameter int unsigned H_SYNC_LEN        = VTG_H_SYNC_LEN,
    parameter int unsigned RW                = VTG_RW,
    parameter int unsigned RASTER_START_NTSC = VTG_RASTER_START_NTSC,
    parameter int unsigned RASTER_START_PAL  = VTG_RASTER_START_PAL,
    parameter int unsigned V_ACT_START       = VTG_V_ACT_START,
    parameter int unsigned V_ACT_END         = VTG_V_ACT_END,
    parameter int unsigned V_SYNC_LEN        = VTG_V_SYNC_LEN
) (
    input  logic                         CLK_24MB,
    input  logic                         RESETP,
    input  logic                         VMODE,
    input  logic [RW-1:0]                IRQ_LINE,
    input  logic                         IRQ_ENABLE,
    output logic                         PCE,
    output logic [$clog2(H_TOTAL)-1:0]   PIXELC,
    output logic [RW-1:0]                RASTERC,
    output logic                         HSYNC,
    output logic                         VSYNC,
    output logic                         SYNC,
    output logic                         BNK,
    output logic                         BNKB,
    output logic                         CHBL,
    output logic                         FIELD,
    output logic                         LINE_START,
    output logic                         RASTER_IRQ
);

    localparam int unsigned DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned PW   = $clog2(H_TOTAL);
    localparam int unsigned RMAX = (1 << RW) - 1;

    logic [DW-1:0] div, div_next;
    logic [PW-1:0] pix_next;
    logic [RW-1:0] ras_next, start_load;
    logic          div_tc, pix_tc, ras_tc;
    logic          line_wrap, frame_wrap, irq_hit;
    logic          hs_act, vs_act, hblank, bnk;
    int unsigned   start_next;
    vtg_mode_e     mode_q, mode_next;

    // Reload value follows the live VMODE input; it is only consumed at reset or frame wrap
    assign start_load = RW'(VMODE ? RASTER_START_PAL : RASTER_START_NTSC);

    vtg_counter #(.W(DW), .MAX(CLK_DIV - 1)) u_div (
        .clk(CLK_24MB), .rst(RESETP), .rst_val('0), .en(1'b1), .load(1'b0), .load_val('0),
        .count(div), .tc_c(div_tc), .next_c(div_next)
    );

    vtg_counter #(.W(PW), .MAX(H_TOTAL - 1)) u_pix (
        .clk(CLK_24MB), .rst(RESETP), .rst_val('0), .en(div_tc), .load(1'b0), .load_val('0),
        .count(PIXELC), .tc_c(pix_tc), .next_c(pix_next)
    );

    vtg_counter #(.W(RW), .MAX(RMAX)) u_ras (
        .clk(CLK_24MB), .rst(RESETP), .rst_val(start_load), .en(line_wrap),
        .load(frame_wrap), .load_val(start_load),
        .count(RASTERC), .tc_c(ras_tc), .next_c(ras_next)
    );

    assign line_wrap  = div_tc & pix_tc;
    assign frame_wrap = line_wrap & ras_tc;
    assign mode_next  = frame_wrap ? vtg_mode_e'(VMODE) : mode_q;
    assign start_next = (mode_next == VTG_PAL) ? RASTER_START_PAL : RASTER_START_NTSC;

    // Decodes use next-state counters so each registered output lines up with its counter value
    assign hblank = (32'(pix_next) >= H_ACTIVE);
    assign hs_act = in_window(32'(pix_next), H_SYNC_START, H_SYNC_START + H_SYNC_LEN);
    assign bnk    = !in_window(32'(ras_next), V_ACT_START, V_ACT_END);
    assign vs_act = in_window(32'(ras_next), start_next, start_next + V_SYNC_LEN);

`ifdef VIDEO_TIMING_GEN_RASTER_IRQ_EN
    assign irq_hit = line_wrap & IRQ_ENABLE & (ras_next == IRQ_LINE);
`else
    logic unused_irq;
    assign unused_irq = ^{IRQ_LINE, IRQ_ENABLE};
    assign irq_hit    = 1'b0;
`endif

    always_ff @(posedge CLK_24MB) begin
        if (RESETP) begin
            mode_q     <= vtg_mode_e'(VMODE);
            PCE        <= 1'b0;
            LINE_START <= 1'b0;
            RASTER_IRQ <= 1'b0;
            FIELD      <= 1'b0;
            HSYNC      <= 1'b1;
            VSYNC      <= 1'b0;
            SYNC       <= 1'b0;
            BNK        <= 1'b1;
            BNKB       <= 1'b0;
            CHBL       <= 1'b1;
        end else begin
            mode_q     <= mode_next;
            PCE        <= (div_next == DW'(CLK_DIV - 1));
            LINE_START <= line_wrap;
            RASTER_IRQ <= irq_hit;
            FIELD      <= FIELD ^ frame_wrap;
            HSYNC      <= ~hs_act;
            VSYNC      <= ~vs_act;
            SYNC       <= ~(hs_act ^ vs_act);
            BNK        <= bnk;
            BNKB       <= ~bnk;
            CHBL       <= hblank | bnk;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen using a shortened line (12 pixels) and default vertical geometry.
module tb_video_timing_gen;

    localparam int unsigned CLK_DIV   = 4;
    localparam int unsigned H_TOTAL   = 12;
    localparam int unsigned H_ACTIVE  = 8;
    localparam int unsigned HS_START  = 9;
    localparam int unsigned HS_LEN    = 2;
    localparam int unsigned LINE_CLKS = CLK_DIV * H_TOTAL;

    logic       clk = 1'b0;
    logic       resetp, vmode, irq_enable;
    logic [8:0] irq_line;
    logic       pce, hsync, vsync, sync, bnk, bnkb, chbl, field, line_start, raster_irq;
    logic [3:0] pixelc;
    logic [8:0] rasterc;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_ls  = 0;
    int stray    = 0;
    int exp_ras, exp_field, exp_mode, frame_lines;

    always #5 clk = ~clk;

    video_timing_gen #(
        .CLK_DIV(CLK_DIV), .H_TOTAL(H_TOTAL), .H_ACTIVE(H_ACTIVE),
        .H_SYNC_START(HS_START), .H_SYNC_LEN(HS_LEN)
    ) dut (
        .CLK_24MB(clk), .RESETP(resetp), .VMODE(vmode), .IRQ_LINE(irq_line),
        .IRQ_ENABLE(irq_enable), .PCE(pce), .PIXELC(pixelc), .RASTERC(rasterc),
        .HSYNC(hsync), .VSYNC(vsync), .SYNC(sync), .BNK(bnk), .BNKB(bnkb), .CHBL(chbl),
        .FIELD(field), .LINE_START(line_start), .RASTER_IRQ(raster_irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (raster model 0x%0h, t=%0t)",
                     tag, got, exp, exp_ras, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic bnk_of(input int r);
        return (r < 'h110) || (r >= 'h1F0);
    endfunction

    function automatic logic vs_of(input int r, input int m);
        int s;
        s = m ? 'h0C8 : 'h0F8;
        return (r >= s) && (r < s + 8);
    endfunction

    function automatic logic hs_of(input int p);
        return (p >= HS_START) && (p < HS_START + HS_LEN);
    endfunction

    task automatic check_reset_vals(input int start);
        check("rst_rasterc", 32'(rasterc), start);
        check("rst_pixelc", 32'(pixelc), 0);
        check("rst_pce", 32'(pce), 0);
        check("rst_line_start", 32'(line_start), 0);
        check("rst_irq", 32'(raster_irq), 0);
        check("rst_field", 32'(field), 0);
        check("rst_hsync", 32'(hsync), 1);
        check("rst_vsync", 32'(vsync), 0);
        check("rst_sync", 32'(sync), 0);
        check("rst_bnk", 32'(bnk), 1);
        check("rst_bnkb", 32'(bnkb), 0);
        check("rst_chbl", 32'(chbl), 1);
    endtask

    task automatic model_reset(input int mode);
        exp_mode    = mode;
        exp_ras     = mode ? 'h0C8 : 'h0F8;
        exp_field   = 0;
        frame_lines = 1;
        last_ls     = cyc;
    endtask

    // Advance to the next LINE_START, optionally checking every pixel of the current line
    task automatic next_line(input bit detail);
        int  o;
        bit  seen;
        logic exp_irq, hs, vs, bk;
        seen = 1'b0;
        while (cyc - last_ls < LINE_CLKS + 4) begin
            tick();
            o = cyc - last_ls;
            if (line_start) begin
                seen = 1'b1;
                break;
            end
            if (raster_irq) stray++;
            if (detail) begin
                hs = hs_of(o / CLK_DIV);
                vs = vs_of(exp_ras, exp_mode);
                bk = bnk_of(exp_ras);
                check("px_pixelc", 32'(pixelc), o / CLK_DIV);
                check("px_pce", 32'(pce), (o % CLK_DIV) == CLK_DIV - 1);
                check("px_hsync", 32'(hsync), !hs);
                check("px_vsync", 32'(vsync), !vs);
                check("px_sync", 32'(sync), !(hs ^ vs));
                check("px_chbl", 32'(chbl), ((o / CLK_DIV) >= H_ACTIVE) || bk);
            end
        end
        if (!seen) begin
            check("line_start_seen", 0, 1);
            last_ls = cyc;
            return;
        end
        check("line_period", cyc - last_ls, LINE_CLKS);
        last_ls = cyc;
        if (exp_ras == 'h1FF) begin
            check("frame_len", frame_lines, exp_mode ? 312 : 264);
            exp_mode    = vmode;
            exp_ras     = exp_mode ? 'h0C8 : 'h0F8;
            exp_field   = exp_field ^ 1;
            frame_lines = 1;
        end else begin
            exp_ras++;
            frame_lines++;
        end
`ifdef VIDEO_TIMING_GEN_RASTER_IRQ_EN
        exp_irq = irq_enable && (exp_ras == int'(irq_line));
`else
        exp_irq = 1'b0;
`endif
        vs = vs_of(exp_ras, exp_mode);
        bk = bnk_of(exp_ras);
        check("ls_rasterc", 32'(rasterc), exp_ras);
        check("ls_pixelc", 32'(pixelc), 0);
        check("ls_pce", 32'(pce), 0);
        check("ls_field", 32'(field), exp_field);
        check("ls_bnk", 32'(bnk), bk);
        check("ls_bnkb", 32'(bnkb), !bk);
        check("ls_vsync", 32'(vsync), !vs);
        check("ls_hsync", 32'(hsync), 1);
        check("ls_sync", 32'(sync), !vs);
        check("ls_chbl", 32'(chbl), bk);
        check("ls_irq", 32'(raster_irq), exp_irq);
    endtask

    task automatic run_lines(input int n);
        for (int i = 0; i < n; i++) begin
            next_line(exp_ras == 'h0F8 || exp_ras == 'h0CB || exp_ras == 'h130 || exp_ras == 'h1FF);
        end
    endtask

    initial begin
        int k;
        resetp     = 1'b1;
        vmode      = 1'b0;
        irq_line   = 9'h120;
        irq_enable = 1'b1;
        tick();
        tick();
        check_reset_vals('h0F8);

        // Release reset and time the first pixel enable
        resetp = 1'b0;
        model_reset(0);
        k = 0;
        while (k < 10) begin
            tick();
            k++;
            if (pce) break;
        end
        check("first_pce_delay", k, 3);
        check("first_pce_pixelc", 32'(pixelc), 0);
        tick();
        check("pixelc_after_pce", 32'(pixelc), 1);
        check("pce_one_cycle", 32'(pce), 0);
        next_line(1'b1);
        run_lines(263);

        // Second NTSC frame: IRQ disabled, PAL requested mid-frame
        irq_enable = 1'b0;
        run_lines('h150 - 'h0F8);
        check("at_raster_150", 32'(rasterc), 'h150);
        vmode = 1'b1;
        run_lines(264 - ('h150 - 'h0F8));
        check("pal_reload", 32'(rasterc), 'h0C8);

        // PAL frame with compare on the start value: IRQ coincides with wrap and FIELD toggle
        irq_line   = 9'h0C8;
        irq_enable = 1'b1;
        run_lines(312);

        // Reset pulse at raster 0x180
        irq_enable = 1'b0;
        run_lines('h180 - 'h0C8);
        check("at_raster_180", 32'(rasterc), 'h180);
        for (int i = 0; i < 10; i++) tick();
        resetp = 1'b1;
        tick();
        check_reset_vals('h0C8);
        resetp = 1'b0;
        model_reset(1);

        // Full PAL frame from reset
        irq_line   = 9'h120;
        irq_enable = 1'b1;
        run_lines(312);

        check("stray_irq", stray, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
